// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter, the baud generator
// and the receiver.
//
// Contents:
//   DEFAULT_DATA_BITS  data bits per frame when the instance does not override
//   DEFAULT_STOP_BITS  stop bit periods per frame when not overridden
//   BAUD_DIVISOR       CLKIN cycles per bit period produced by the baud generator
//   uart_state_t       transmitter FSM state encoding
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;
    localparam int BAUD_DIVISOR      = 415;

    // Fixed encodings so that logic elsewhere comparing raw state values keeps
    // working if members are ever reordered.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial transmitter, LSB first, one bit per baud tick.
//
// A byte offered with valid while ready is high is captured; the frame waits
// for the next baud tick (SYNC) and then sends start, DATA_BITS data bits,
// optional even parity and STOP_BITS stop periods, each one baud period long.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bit periods (1..2)
//
// Ports:
//   CLKIN   in   clock, all state changes on its rising edge
//   RESETN  in   asynchronous active-low reset
//   baud    in   one-cycle bit-period tick from the baud generator
//   data    in   byte to send; bits above DATA_BITS-1 are ignored
//   valid   in   data holds a byte to send
//   ready   out  high while idle; accept happens on valid & ready
//   tx      out  serial line, idles high
//   done    out  one-cycle pulse at the end of the last stop period
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even parity bit is sent between the
//                      data bits and the stop bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic       CLKIN,
    input  logic       RESETN,
    input  logic       baud,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    // A limit of 1 would give a zero-width counter, so keep at least one bit.
    localparam int BIT_CNT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int STOP_CNT_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [STOP_CNT_W-1:0] STOP_LAST = STOP_CNT_W'(STOP_BITS - 1);

    uart_state_t             state_reg;
    logic [DATA_BITS-1:0]    shreg_reg;
    logic [BIT_CNT_W-1:0]    bit_cnt_reg;
    logic [STOP_CNT_W-1:0]   stop_cnt_reg;
    logic                    tx_reg;
    logic                    done_reg;

`ifdef UART_TX_PARITY_EN
    logic                    parity_reg;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // Upper data bits are deliberately dropped for narrow frames.
    generate
        if (DATA_BITS < 8) begin : g_data_unused
            logic unused_data_hi;
            assign unused_data_hi = ^data[7:DATA_BITS];
        end
    endgenerate

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= ST_IDLE;
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                // baud is ignored here so a tick coinciding with the accept
                // edge cannot start the frame early.
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (valid) begin
                        shreg_reg    <= data[DATA_BITS-1:0];
                        bit_cnt_reg  <= '0;
                        stop_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                        // Captured now because the shift register is consumed
                        // by the time the parity bit goes out.
                        parity_reg   <= even_parity(data[DATA_BITS-1:0]);
`endif
                        state_reg    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (baud) begin
                        tx_reg    <= 1'b0;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud) begin
                        tx_reg    <= shreg_reg[0];
                        shreg_reg <= shreg_reg >> 1;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud) begin
                        if (bit_cnt_reg != BIT_LAST) begin
                            tx_reg      <= shreg_reg[0];
                            shreg_reg   <= shreg_reg >> 1;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= ST_PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud) begin
                        tx_reg    <= 1'b1;
                        state_reg <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud) begin
                        if (stop_cnt_reg == STOP_LAST) begin
                            stop_cnt_reg <= '0;
                            done_reg     <= 1'b1;
                            state_reg    <= ST_IDLE;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = (state_reg == ST_IDLE);
    assign tx    = tx_reg;
    assign done  = done_reg;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps

module tb_uart_tx;
    import uart_pkg::*;

    localparam int BP = BAUD_DIVISOR;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB8 = 1 + 8 + PAR + 1;   // frame length, 8 data bits, 1 stop

    logic       CLKIN  = 1'b0;
    logic       RESETN = 1'b0;
    logic       baud   = 1'b0;
    logic [7:0] data   = 8'h00;
    logic [7:0] data2  = 8'h00;
    logic       valid  = 1'b0;
    logic       valid2 = 1'b0;
    logic       ready, tx, done;
    logic       ready2, tx2, done2;

    int checks = 0;
    int errors = 0;
    int bcnt   = 0;
    int sel    = 0;   // 0: default instance, 1: 7-bit / 2-stop instance

    logic m_tx, m_ready, m_done;
    assign m_tx    = (sel != 0) ? tx2    : tx;
    assign m_ready = (sel != 0) ? ready2 : ready;
    assign m_done  = (sel != 0) ? done2  : done;

    uart_tx dut (
        .CLKIN (CLKIN),
        .RESETN(RESETN),
        .baud  (baud),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .done  (done)
    );

    uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
        .CLKIN (CLKIN),
        .RESETN(RESETN),
        .baud  (baud),
        .data  (data2),
        .valid (valid2),
        .ready (ready2),
        .tx    (tx2),
        .done  (done2)
    );

    always #5 CLKIN = ~CLKIN;

    // Baud generator: one-cycle tick every BP cycles, updated just after the edge.
    always @(posedge CLKIN) begin
        #1;
        bcnt = (bcnt == BP - 1) ? 0 : bcnt + 1;
        baud = (bcnt == 0);
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLKIN);
        #2;
    endtask

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference frame: bit i is the i-th symbol on the line.
    function automatic logic [11:0] model_frame(input logic [7:0] d, input int dbits,
                                                input int sbits, output int n);
        int word, p, ones, b;
        word = 0; p = 1; ones = 0;           // position 0 is the start bit (0)
        for (int i = 0; i < dbits; i++) begin
            b = (int'(d) >> i) & 1;
            ones += b;
            word += b << p;
            p++;
        end
        if (PAR != 0) begin
            word += (ones % 2) << p;
            p++;
        end
        for (int s = 0; s < sbits; s++) begin
            word += 1 << p;
            p++;
        end
        n = p;
        return word[11:0];
    endfunction

    task automatic accept(input logic [7:0] d, input bit align);
        int n = 0;
        while (!(m_ready && (!align || baud)) && n < 3000) begin
            step();
            n++;
        end
        chk(n < 3000, "accept wait", n, 3000);
        if (sel != 0) begin data2 = d; valid2 = 1'b1; end
        else          begin data  = d; valid  = 1'b1; end
        step();
        valid  = 1'b0;
        valid2 = 1'b0;
    endtask

    // Called just after the accept edge; ends at the negedge following done.
    task automatic check_frame(input string tag, input logic [11:0] exp, input int nb,
                               output int sync_n);
        int bad, n;
        chk(!m_ready && !m_done, {tag, " accepted"}, int'(m_ready), 0);
        n = 0; bad = 0;
        while (!baud && n < BP + 5) begin
            @(negedge CLKIN);
            if (m_tx !== 1'b1 || m_done !== 1'b0) bad++;
            n++;
            step();
        end
        @(negedge CLKIN);
        if (m_tx !== 1'b1) bad++;
        n++;
        sync_n = n;
        chk(bad == 0 && n <= BP, {tag, " sync idle"}, bad, 0);
        @(posedge CLKIN);
        for (int i = 0; i < nb; i++) begin
            bad = 0;
            for (int c = 0; c < BP; c++) begin
                @(negedge CLKIN);
                if (m_tx !== exp[i] || m_done !== 1'b0 || m_ready !== 1'b0) bad++;
            end
            chk(bad == 0, $sformatf("%s bit%0d want %0d bad cycles", tag, i, exp[i]), bad, 0);
        end
        @(negedge CLKIN);
        chk(m_done === 1'b1 && m_tx === 1'b1 && m_ready === 1'b1, {tag, " done"},
            int'(m_done), 1);
        $display("frame %s: exp=%03h bits=%0d sync=%0d checks=%0d errors=%0d",
                 tag, exp, nb, sync_n, checks, errors);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [11:0] exp;
        bit          align;
    } vec_t;

    initial begin
        vec_t        tbl[4];
        int          sn, nb;
        logic [7:0]  rd;
        logic [11:0] rexp;

        tbl[0] = '{8'h55, (PAR != 0) ? 12'h4AA : 12'h2AA, 1'b0};
        tbl[1] = '{8'h07, (PAR != 0) ? 12'h60E : 12'h20E, 1'b0};
        tbl[2] = '{8'hA3, (PAR != 0) ? 12'h546 : 12'h346, 1'b1};
        tbl[3] = '{8'h81, (PAR != 0) ? 12'h502 : 12'h302, 1'b0};

        // Reset state
        repeat (3) step();
        chk(tx === 1'b1,    "reset tx",    int'(tx),    1);
        chk(ready === 1'b1, "reset ready", int'(ready), 1);
        chk(done === 1'b0,  "reset done",  int'(done),  0);
        RESETN = 1'b1;

        // Table frames; the first accept lands on the first edge after release.
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            accept(tbl[i].d, tbl[i].align);
            check_frame($sformatf("tbl%0d_%02h", i, tbl[i].d), tbl[i].exp, NB8, sn);
            if (tbl[i].align) chk(sn == BP, "aligned sync length", sn, BP);
        end

        // valid held high across two frames; data changes mid-frame are ignored.
        while (!ready) step();
        data = 8'h01; valid = 1'b1;
        step();
        data = 8'hFF;
        check_frame("hold01", (PAR != 0) ? 12'h602 : 12'h202, NB8, sn);
        step();
        valid = 1'b0;
        check_frame("holdFF", (PAR != 0) ? 12'h5FE : 12'h3FE, NB8, sn);

        // Reset in the middle of the data bits of 0x00.
        accept(8'h00, 1'b0);
        repeat (3 * BP + 200) step();
        chk(tx === 1'b0, "pre-reset tx low", int'(tx), 0);
        #1 RESETN = 1'b0;
        #1;
        chk(tx === 1'b1 && ready === 1'b1 && done === 1'b0, "async reset", int'(tx), 1);
        repeat (2) step();
        RESETN = 1'b1;
        accept(8'h81, 1'b0);
        check_frame("post_reset_81", (PAR != 0) ? 12'h502 : 12'h302, NB8, sn);

        // Seven data bits, two stop periods: bit 7 of 0xF0 is dropped.
        sel = 1;
        accept(8'hF0, 1'b0);
        check_frame("stop2_F0", (PAR != 0) ? 12'h7E0 : 12'h3E0, 10 + PAR, sn);
        sel = 0;

        // Random bytes against the reference model.
        for (int r = 0; r < 3; r++) begin
            rd   = 8'($urandom_range(0, 255));
            rexp = model_frame(rd, 8, 1, nb);
            accept(rd, 1'b0);
            check_frame($sformatf("rand_%02h", rd), rexp, nb, sn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001: Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame (legal range 5..8).
- REQ-002: Parameter STOP_BITS, default 1, SHALL set the number of stop bit periods (legal 1..2).
- REQ-003: CLKIN  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: RESETN  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: baud  input  1  SHALL be the one-cycle bit-period tick from the baud generator; it is high for one CLKIN cycle once per bit period.
- REQ-006: data  input  8  SHALL carry the byte to send; bits above DATA_BITS-1 are ignored.
- REQ-007: valid  input  1  SHALL indicate that data holds a byte to send.
- REQ-008: ready  output  1  SHALL be high exactly when state is IDLE; the byte is accepted on an edge where valid and ready are both high.
- REQ-009: tx  output  1  SHALL be the serial line, idle high, LSB first.
- REQ-010: done  output  1  SHALL pulse high for one cycle when the final stop period ends.

Function
- REQ-011: FSM states SHALL be IDLE, SYNC, START, DATA, PARITY, STOP; all transitions except IDLE->SYNC occur only on cycles with baud=1.
- REQ-012: IDLE: tx=1; on accept, data SHALL be captured into the shift register, the bit counter cleared, and the state set to SYNC; baud is ignored in IDLE, including on the accept cycle.
- REQ-013: SYNC: on baud, tx<=0 and the state SHALL go to START.
- REQ-014: START: on baud, tx<=shreg[0], shreg shifts right, and the state SHALL go to DATA.
- REQ-015: DATA: on baud with bit count < DATA_BITS-1, tx SHALL take the next bit and the count increments; at DATA_BITS-1, tx<=parity and the state goes to PARITY when parity is enabled, else tx<=1 and the state goes to STOP.
- REQ-016: PARITY: on baud, tx<=1 and the state SHALL go to STOP.
- REQ-017: STOP: on baud, the stop counter SHALL increment; at STOP_BITS-1 the state goes to IDLE and done pulses on that same edge.
- REQ-018: Every bit (start, data, parity, stop) SHALL last exactly one baud period; tx falls on the first baud tick strictly after the accept edge.
- REQ-019: valid asserted while ready=0 SHALL be ignored; there is no queueing.
- REQ-020: A new byte SHALL be acceptable in the cycle immediately after done; back-to-back frames add no extra idle period beyond the SYNC wait.
- REQ-021: Bit and stop counters SHALL be sized with $clog2 of their limit and SHALL never wrap within a frame.

Reset
- REQ-022: RESETN=0 SHALL immediately force state=IDLE, tx=1, done=0, counters=0, and shreg=0, including mid-frame; ready=1 while in reset.
- REQ-023: The first accept SHALL be possible on the first rising edge after RESETN deasserts.

Configuration
- REQ-024: With UART_TX_PARITY_EN defined, a PARITY state SHALL emit even parity (XOR of the DATA_BITS data bits) between data and stop; without it, the PARITY state and parity logic SHALL be absent and DATA goes directly to STOP.

Structure
- REQ-025: Package uart_pkg SHALL hold the state enum typedef, the default DATA_BITS/STOP_BITS constants and the baud divisor constant (415); it is shared with the baud generator and the future uart_rx.
- REQ-026: No sub-module; the block SHALL be a single module whose parity XOR is a local function.

Verification (bench drives baud from the baud generator, 415-cycle period)
- REQ-027: Reset, then send 0x55 with no parity -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 415 cycles; done pulses once; ready returns to 1.
- REQ-028: UART_TX_PARITY_EN defined, send 0x07 -> 8 data bits LSB first, then parity bit = 1, then stop = 1.
- REQ-029: Assert valid with 0xA3 in the same cycle as baud=1 -> the start bit begins at the next baud tick, not this one.
- REQ-030: Hold valid continuously with 0x01 then 0xFF -> second accept occurs the cycle after done; valid during the frame is ignored.
- REQ-031: Assert RESETN=0 mid-DATA of 0x00 -> tx=1 asynchronously; after release, ready=1 and a new frame 0x81 transmits correctly.
- REQ-032: STOP_BITS=2, send 0xF0 -> stop high for 830 cycles before done.
